conv_tile_sequencer: RTL and testbench

- Hardware replacement for the software-driven convolution command stream into dnn_hw_top.
- Latches a layer configuration on start, then walks filters, output tiles, channels and filter taps.
- For each step it emits the fsm_input command sequence plus activation and weight SRAM addresses.
- Generalises the current flow to stride > 1, output dims not a multiple of the MAC array (lane/row masks) and a tile-level output handshake.

---
 rtl/conv_tile_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_conv_tile_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_sequencer.sv
// Convolution tile sequencer: walks filters, output tiles, channels and filter taps, emitting the
// dnn_hw_top command stream and SRAM addresses. Define CONV_SEQ_PERF_EN for perf counters.
module conv_tile_sequencer #(
    parameter int unsigned X_DIM       = 4,
    parameter int unsigned Y_DIM       = 4,
    parameter int unsigned DIM_W       = 10,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned EXEC_CYCLES = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_actn_h,
    input  logic [DIM_W-1:0]  cfg_actn_w,
    input  logic [DIM_W-1:0]  cfg_actn_c,
    input  logic [DIM_W-1:0]  cfg_filt_h,
    input  logic [DIM_W-1:0]  cfg_filt_w,
    input  logic [DIM_W-1:0]  cfg_num_filt,
    input  logic [2:0]        cfg_stride,
    output logic              busy,
    output logic              done,
    output logic [2:0]        fsm_cmd,
    output logic              pe_start,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W-1:0] if_base_addr,
    output logic [X_DIM-1:0]  if_lane_mask,
    output logic              acc_clr,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [DIM_W-1:0]  tile_n,
    output logic [DIM_W-1:0]  tile_oy,
    output logic [DIM_W-1:0]  tile_ox,
    output logic [Y_DIM-1:0]  tile_row_mask,
    output logic [X_DIM-1:0]  tile_col_mask
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_taps
`endif
);

    localparam logic [2:0] CMD_DEFAULT = 3'b001;
    localparam logic [2:0] CMD_LD_WT   = 3'b010;
    localparam logic [2:0] CMD_LD_IFB  = 3'b011;
    localparam logic [2:0] CMD_LD_IFP  = 3'b100;
    localparam logic [2:0] CMD_EXEC    = 3'b101;
    localparam logic [2:0] CMD_UNLD    = 3'b110;

    localparam int unsigned CYC_W  = $clog2(EXEC_CYCLES > 3 ? EXEC_CYCLES : 3);
    localparam int unsigned BEAT_W = $clog2(Y_DIM + 1);
    localparam int unsigned EXT_W  = DIM_W + 1;

    typedef enum logic [3:0] {
        StIdle, StCfg, StGap, StWt, StIfb, StIfp, StExe, StPost, StUnl, StSet, StTile, StDone
    } state_e;

    state_e state_q, state_d;

    logic [DIM_W-1:0]  h_q, w_q, c_q, fh_q, fw_q, nf_q, oh_q, ow_q;
    logic [2:0]        s_q;
    logic [DIM_W-1:0]  n_q, oy_q, ox_q, ci_q, fwi_q, fhi_q;
    logic [CYC_W-1:0]  cyc_q, len;
    logic [BEAT_W-1:0] beat_q;
    logic [DIM_W-1:0]  oh_calc, ow_calc;
    logic [ADDR_W-1:0] a_row, wt_calc, if_calc;
    logic beat_state, run_state, cyc_last, beat_last, step_end, row_ok, cfg_zero;
    logic fh_last, fw_last, c_last, tap_last, x_last, y_last, n_last, tile_last;

    always_comb begin
        len = CYC_W'(1);
        unique case (state_q)
            StGap, StSet, StIfb: len = CYC_W'(2);
            StIfp, StUnl:        len = CYC_W'(3);
            StExe:               len = CYC_W'(EXEC_CYCLES);
            default:             len = CYC_W'(1);
        endcase
        beat_state = (state_q == StIfb) || (state_q == StIfp) || (state_q == StUnl);
        run_state  = (state_q >= StGap) && (state_q <= StSet);
        cyc_last   = (cyc_q == len - CYC_W'(1));
        beat_last  = (beat_q == BEAT_W'(Y_DIM));
        step_end   = cyc_last && (!beat_state || beat_last);

        fh_last   = (fhi_q == fh_q - DIM_W'(1));
        fw_last   = (fwi_q == fw_q - DIM_W'(1));
        c_last    = (ci_q == c_q - DIM_W'(1));
        tap_last  = fh_last && fw_last && c_last;
        x_last    = ({1'b0, ox_q} + EXT_W'(X_DIM)) >= {1'b0, ow_q};
        y_last    = ({1'b0, oy_q} + EXT_W'(Y_DIM)) >= {1'b0, oh_q};
        n_last    = (n_q == nf_q - DIM_W'(1));
        tile_last = x_last && y_last && n_last;

        // Degenerate dimensions would underflow the loop bounds, so they also yield no tiles.
        cfg_zero = (fh_q > h_q) || (fw_q > w_q) || (fh_q == '0) || (fw_q == '0) ||
                   (c_q == '0) || (nf_q == '0);
        oh_calc  = (h_q - fh_q) / DIM_W'(s_q) + DIM_W'(1);
        ow_calc  = (w_q - fw_q) / DIM_W'(s_q) + DIM_W'(1);

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCfg;
            StCfg:   state_d = cfg_zero ? StDone : StGap;
            StGap:   if (step_end) state_d = StWt;
            StWt:    if (step_end) state_d = StIfb;
            StIfb:   if (step_end) state_d = StIfp;
            StIfp:   if (step_end) state_d = StExe;
            StExe:   if (step_end) state_d = StPost;
            StPost:  if (step_end) state_d = StUnl;
            StUnl:   if (step_end) state_d = StSet;
            StSet:   if (step_end) state_d = tap_last ? StTile : StGap;
            StTile:  if (tile_ready) state_d = tile_last ? StDone : StGap;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int j = 0; j < X_DIM; j++) begin
            tile_col_mask[j] = ({1'b0, ox_q} + EXT_W'(j)) < {1'b0, ow_q};
        end
        for (int i = 0; i < Y_DIM; i++) begin
            tile_row_mask[i] = ({1'b0, oy_q} + EXT_W'(i)) < {1'b0, oh_q};
        end
        row_ok  = ({1'b0, oy_q} + EXT_W'(beat_q)) < {1'b0, oh_q};
        a_row   = (ADDR_W'(oy_q) + ADDR_W'(beat_q)) * ADDR_W'(s_q) + ADDR_W'(fhi_q);
        if_calc = ADDR_W'(ci_q) * ADDR_W'(h_q) * ADDR_W'(w_q) + a_row * ADDR_W'(w_q) +
                  ADDR_W'(ox_q) * ADDR_W'(s_q) + ADDR_W'(fwi_q);
        wt_calc = (ADDR_W'(n_q) * ADDR_W'(c_q) + ADDR_W'(ci_q)) * ADDR_W'(fh_q) * ADDR_W'(fw_q) +
                  ADDR_W'(fwi_q) * ADDR_W'(fh_q) + ADDR_W'(fhi_q);
    end

    always_comb begin
        fsm_cmd      = CMD_DEFAULT;
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        pe_start     = (state_q == StGap) && (cyc_q == '0);
        acc_clr      = run_state && (ci_q == '0) && (fwi_q == '0) && (fhi_q == '0);
        tile_valid   = (state_q == StTile);
        wt_addr      = '0;
        if_base_addr = '0;
        if_lane_mask = '0;
        unique case (state_q)
            StWt: begin
                fsm_cmd = CMD_LD_WT;
                wt_addr = wt_calc;
            end
            StIfb: begin
                fsm_cmd = CMD_LD_IFB;
                if (!beat_last) begin
                    if_base_addr = if_calc;
                    if_lane_mask = row_ok ? tile_col_mask : '0;
                end
            end
            StIfp:   fsm_cmd = CMD_LD_IFP;
            StExe:   fsm_cmd = CMD_EXEC;
            StUnl:   fsm_cmd = CMD_UNLD;
            default: fsm_cmd = CMD_DEFAULT;
        endcase
    end

    assign tile_n  = n_q;
    assign tile_oy = oy_q;
    assign tile_ox = ox_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            h_q  <= '0; w_q  <= '0; c_q  <= '0; fh_q <= '0; fw_q <= '0; nf_q <= '0;
            oh_q <= '0; ow_q <= '0; s_q  <= 3'd1;
            n_q  <= '0; oy_q <= '0; ox_q <= '0; ci_q <= '0; fwi_q <= '0; fhi_q <= '0;
            cyc_q <= '0; beat_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                h_q  <= cfg_actn_h;
                w_q  <= cfg_actn_w;
                c_q  <= cfg_actn_c;
                fh_q <= cfg_filt_h;
                fw_q <= cfg_filt_w;
                nf_q <= cfg_num_filt;
                s_q  <= (cfg_stride == 3'd0) ? 3'd1 : cfg_stride;
                n_q  <= '0; oy_q <= '0; ox_q <= '0; ci_q <= '0; fwi_q <= '0; fhi_q <= '0;
                cyc_q <= '0; beat_q <= '0;
            end
            if (state_q == StCfg) begin
                oh_q <= oh_calc;
                ow_q <= ow_calc;
            end
            if (run_state) begin
                if (cyc_last) begin
                    cyc_q <= '0;
                    if (beat_state) beat_q <= beat_last ? '0 : beat_q + BEAT_W'(1);
                end else begin
                    cyc_q <= cyc_q + CYC_W'(1);
                end
            end
            // Tap order, innermost first: fh, fw, c.
            if (state_q == StSet && step_end) begin
                if (fh_last) begin
                    fhi_q <= '0;
                    if (fw_last) begin
                        fwi_q <= '0;
                        ci_q  <= c_last ? '0 : ci_q + DIM_W'(1);
                    end else begin
                        fwi_q <= fwi_q + DIM_W'(1);
                    end
                end else begin
                    fhi_q <= fhi_q + DIM_W'(1);
                end
            end
            if (state_q == StTile && tile_ready && !tile_last) begin
                if (x_last) begin
                    ox_q <= '0;
                    if (y_last) begin
                        oy_q <= '0;
                        n_q  <= n_q + DIM_W'(1);
                    end else begin
                        oy_q <= oy_q + DIM_W'(Y_DIM);
                    end
                end else begin
                    ox_q <= ox_q + DIM_W'(X_DIM);
                end
            end
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_taps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_taps_q   <= '0;
        end else if (state_q == StIdle && start) begin
            perf_cycles_q <= '0;
            perf_taps_q   <= '0;
        end else begin
            if (busy && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (state_q == StSet && step_end && perf_taps_q != '1) perf_taps_q <= perf_taps_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_taps   = perf_taps_q;
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer: table of layer configurations run end to end, plus directed
// sequences for addresses, partial-tile masks, tile backpressure and reset mid-run.
module tb_conv_tile_sequencer;

    localparam int XD = 4;
    localparam int YD = 4;

    logic        clk = 1'b0;
    logic        rst, start, tile_ready;
    logic [9:0]  cfg_actn_h, cfg_actn_w, cfg_actn_c, cfg_filt_h, cfg_filt_w, cfg_num_filt;
    logic [2:0]  cfg_stride;
    logic        busy, done, pe_start, acc_clr, tile_valid;
    logic [2:0]  fsm_cmd;
    logic [19:0] wt_addr, if_base_addr;
    logic [3:0]  if_lane_mask, tile_row_mask, tile_col_mask;
    logic [9:0]  tile_n, tile_oy, tile_ox;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_taps;
`endif

    conv_tile_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_actn_h   (cfg_actn_h),
        .cfg_actn_w   (cfg_actn_w),
        .cfg_actn_c   (cfg_actn_c),
        .cfg_filt_h   (cfg_filt_h),
        .cfg_filt_w   (cfg_filt_w),
        .cfg_num_filt (cfg_num_filt),
        .cfg_stride   (cfg_stride),
        .busy         (busy),
        .done         (done),
        .fsm_cmd      (fsm_cmd),
        .pe_start     (pe_start),
        .wt_addr      (wt_addr),
        .if_base_addr (if_base_addr),
        .if_lane_mask (if_lane_mask),
        .acc_clr      (acc_clr),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .tile_n       (tile_n),
        .tile_oy      (tile_oy),
        .tile_ox      (tile_ox),
        .tile_row_mask(tile_row_mask),
        .tile_col_mask(tile_col_mask)
`ifdef CONV_SEQ_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_taps    (perf_taps)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int h, w, c, fh, fw, nf, s;
        int oh, ow, tiles, busy;
    } vec_t;

    vec_t vecs[7];
    int   total = 0;
    int   bad = 0;
    int   busy_cnt, done_cnt, tile_idx, m_oh, m_ow, m_tiles;
    bit   prev_acc;
    int   cnt, viol;
    bit   found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected tile order and masks from the tile index: n outer, then ty, then tx.
    task automatic check_tile();
        int th, tw, r, en, ety, etx;
        logic [3:0] rm, cm;
        th  = (m_oh + YD - 1) / YD;
        tw  = (m_ow + XD - 1) / XD;
        en  = tile_idx / (th * tw);
        r   = tile_idx % (th * tw);
        ety = r / tw;
        etx = r % tw;
        for (int i = 0; i < 4; i++) begin
            rm[i] = (ety * YD + i) < m_oh;
            cm[i] = (etx * XD + i) < m_ow;
        end
        check("tile_n", tile_n, en);
        check("tile_oy", tile_oy, ety * YD);
        check("tile_ox", tile_ox, etx * XD);
        check("tile_row_mask", tile_row_mask, rm);
        check("tile_col_mask", tile_col_mask, cm);
        tile_idx++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                check("done_after_accept", prev_acc, (m_tiles > 0) ? 1 : 0);
            end
            if (tile_valid && tile_ready) check_tile();
            prev_acc = tile_valid && tile_ready;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_cmd"}, fsm_cmd, 1);
        check({tag, "_busy_done"}, {busy, done, pe_start, acc_clr, tile_valid}, 0);
        check({tag, "_addrs"}, wt_addr | if_base_addr, 0);
        check({tag, "_masks"}, {if_lane_mask, tile_row_mask, tile_col_mask}, 0);
        check({tag, "_tile_pos"}, {tile_n, tile_oy, tile_ox}, 0);
    endtask

    task automatic start_run(input vec_t v);
        m_oh = v.oh; m_ow = v.ow; m_tiles = v.tiles;
        tile_idx = 0; busy_cnt = 0; done_cnt = 0;
        tile_ready = 1'b1;
        cfg_actn_h = 10'(v.h); cfg_actn_w = 10'(v.w); cfg_actn_c = 10'(v.c);
        cfg_filt_h = 10'(v.fh); cfg_filt_w = 10'(v.fw); cfg_num_filt = 10'(v.nf);
        cfg_stride = 3'(v.s);
        start = 1'b1;
        step();
        start = 1'b0;
        // Scribble the config after the accepted start; the run must not see it.
        cfg_actn_h = 10'd1; cfg_actn_w = 10'd1; cfg_actn_c = 10'd3;
        cfg_filt_h = 10'd1; cfg_filt_w = 10'd1; cfg_num_filt = 10'd5; cfg_stride = 3'd5;
    endtask

    task automatic finish_run(input vec_t v);
        bit fin;
        fin = 1'b0;
        for (int k = 0; k < 20000 && !fin; k++) begin
            @(negedge clk);
            if (done) fin = 1'b1;
        end
        check("run_done_seen", fin, 1);
        step();
        step();
        check("run_busy_cycles", busy_cnt, v.busy);
        check("run_tiles", tile_idx, v.tiles);
        check("run_done_pulses", done_cnt, 1);
        check("run_idle_busy", busy, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         h   w   c  fh fw nf  s  oh ow tiles  busy
        vecs[0] = '{10, 10, 2, 3, 3, 2, 1, 8, 8, 8, 10522};
        vecs[1] = '{ 9,  9, 1, 3, 3, 1, 2, 4, 4, 1,   660};
        vecs[2] = '{ 7,  7, 1, 3, 3, 1, 1, 5, 5, 4,  2634};
        vecs[3] = '{ 2,  2, 1, 3, 3, 1, 1, 0, 0, 0,     2};
        vecs[4] = '{ 5,  6, 1, 2, 1, 1, 0, 4, 6, 2,   296};
        vecs[5] = '{10, 10, 1, 1, 1, 1, 3, 4, 4, 1,    76};
        vecs[6] = '{ 8, 11, 1, 2, 3, 1, 2, 4, 5, 2,   880};

        rst = 1'b1; start = 1'b0; tile_ready = 1'b0;
        cfg_actn_h = '0; cfg_actn_w = '0; cfg_actn_c = '0;
        cfg_filt_h = '0; cfg_filt_w = '0; cfg_num_filt = '0; cfg_stride = '0;
        m_oh = 0; m_ow = 0; m_tiles = 0; tile_idx = 0; busy_cnt = 0; done_cnt = 0;
        repeat (3) step();
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            start_run(vecs[i]);
            if (vecs[i].tiles > 0) begin
                repeat (3) step();
                start = 1'b1;   // ignored while busy
                step();
                start = 1'b0;
            end
            finish_run(vecs[i]);
`ifdef CONV_SEQ_PERF_EN
            if (i == 0) begin
                check("perf_taps", perf_taps, 144);
                check("perf_cycles", perf_cycles, vecs[i].busy);
            end
`endif
        end

        // 9x9 stride 2: tap 7 is fh=1, fw=2.
        start_run(vecs[1]);
        cnt = 0; found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (pe_start) begin
                cnt++;
                if (cnt == 1) check("tap0_acc_clr", acc_clr, 1);
                if (cnt == 8) found = 1'b1;
            end
        end
        check("tap7_found", found, 1);
        check("tap7_acc_clr", acc_clr, 0);
        repeat (2) @(negedge clk);
        check("tap7_wt_cmd", fsm_cmd, 2);
        check("tap7_wt_addr", wt_addr, 7);
        repeat (7) @(negedge clk);
        check("tap7_b3_cmd", fsm_cmd, 3);
        check("tap7_b3_addr", if_base_addr, 65);
        check("tap7_b3_lanes", if_lane_mask, 4'b1111);
        @(negedge clk);
        check("tap7_b3_addr_hold", if_base_addr, 65);
        @(negedge clk);
        check("tap7_flush_cmd", fsm_cmd, 3);
        check("tap7_flush_addr", if_base_addr, 0);
        check("tap7_flush_lanes", if_lane_mask, 0);
        finish_run(vecs[1]);

        // 7x7: partial tiles on the right and bottom edges.
        start_run(vecs[2]);
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (tile_ox == 4 && tile_oy == 0 && fsm_cmd == 3'b011) found = 1'b1;
        end
        check("edge_x_found", found, 1);
        check("edge_x_lanes", if_lane_mask, 4'b0001);
        check("edge_x_col_mask", tile_col_mask, 4'b0001);
        check("edge_x_row_mask", tile_row_mask, 4'b1111);
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (tile_ox == 4 && tile_oy == 4 && fsm_cmd == 3'b011) found = 1'b1;
        end
        check("corner_found", found, 1);
        check("corner_b0_addr", if_base_addr, 32);
        check("corner_b0_lanes", if_lane_mask, 4'b0001);
        check("corner_row_mask", tile_row_mask, 4'b0001);
        repeat (2) @(negedge clk);
        check("corner_b1_addr", if_base_addr, 39);
        check("corner_b1_lanes", if_lane_mask, 0);
        finish_run(vecs[2]);

        // Backpressure in TILE, then reset during DNNEXEC.
        start_run(vecs[2]);
        tile_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (tile_valid) found = 1'b1;
        end
        check("bp_tile_found", found, 1);
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (fsm_cmd !== 3'b001 || tile_valid !== 1'b1 || if_base_addr !== '0 ||
                wt_addr !== '0 || tile_ox !== '0 || busy !== 1'b1) viol++;
        end
        check("bp_hold_violations", viol, 0);
        step();
        tile_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_valid", tile_valid, 1);
        step();
        tile_ready = 1'b0;
        @(negedge clk);
        check("bp_resume_valid", tile_valid, 0);
        check("bp_resume_pe_start", pe_start, 1);
        check("bp_resume_ox", tile_ox, 4);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (fsm_cmd == 3'b101) found = 1'b1;
        end
        check("exe_found", found, 1);
        #1 rst = 1'b1;
        #1 check_idle("rst_mid_exe");
        step();
        step();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (5) step();
        check("rst_no_done", done_cnt, 0);
        check("rst_stays_idle", busy, 0);

        start_run(vecs[1]);
        finish_run(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
